// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter in front of a single register-file write port.
// Grants are combinational; the winning write is registered with one cycle of latency.
module regfile_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic [ADDR_WIDTH-1:0] address_d,
    output logic [DATA_WIDTH-1:0] data_dval,
    output logic                  write_enable,
    input  logic                  stat_clear,
    output logic [15:0]           stall_count
);

    logic [1:0]            sync_q;
    logic                  active;
    logic                  ptr;
    logic                  xfer0;
    logic                  xfer1;
    logic                  xfer_any;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [1:0]            stall_inc;
    logic [16:0]           stall_sum;

    // Reset deassertion passes through two flops, so grants open only after the second edge.
    // NOTE: the async clear reaches sync_q directly, so readies drop the instant reset_n falls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign active = sync_q[1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (active) begin
            req0_ready = req0_valid && (!req1_valid || !ptr);
            req1_ready = req1_valid && (!req0_valid ||  ptr);
        end
    end

    assign xfer0       = req0_valid && req0_ready;
    assign xfer1       = req1_valid && req1_ready;
    assign xfer_any    = xfer0 || xfer1;
    assign sel_address = xfer1 ? req1_address : req0_address;
    assign sel_data    = xfer1 ? req1_data    : req0_data;

    assign stall_inc = {1'b0, req0_valid && !req0_ready} + {1'b0, req1_valid && !req1_ready};
    assign stall_sum = {1'b0, stall_count} + {15'd0, stall_inc};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr          <= 1'b0;
            write_enable <= 1'b0;
            address_d    <= '0;
            data_dval    <= '0;
            stall_count  <= '0;
        end else begin
            // Pointer always lands on the requester that did not just transfer.
            if (xfer_any) begin
                ptr <= xfer0;
            end
            write_enable <= xfer_any && (sel_address != '0);
            // Register 0 is never written, so address/data hold across a zero-address transfer.
            if (xfer_any && (sel_address != '0)) begin
                address_d <= sel_address;
                data_dval <= sel_data;
            end
            if (stat_clear) begin
                stall_count <= '0;
            end else if (stall_sum[16]) begin
                stall_count <= 16'hFFFF;
            end else begin
                stall_count <= stall_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter: handshake, round-robin order, zero-address
// drop, same-address ordering, stall counter saturation/clear and asynchronous reset.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0_valid;
    logic [4:0]  req0_address;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_address;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [4:0]  address_d;
    logic [31:0] data_dval;
    logic        write_enable;
    logic        stat_clear;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req0_valid   (req0_valid),
        .req0_address (req0_address),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_address (req1_address),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .address_d    (address_d),
        .data_dval    (data_dval),
        .write_enable (write_enable),
        .stat_clear   (stat_clear),
        .stall_count  (stall_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        req0_valid   = 1'b0;
        req0_address = '0;
        req0_data    = '0;
        req1_valid   = 1'b0;
        req1_address = '0;
        req1_data    = '0;
        stat_clear   = 1'b0;

        #2;
        check("rst_we",     64'(write_enable), 64'd0);
        check("rst_addr",   64'(address_d),    64'd0);
        check("rst_data",   64'(data_dval),    64'd0);
        check("rst_stall",  64'(stall_count),  64'd0);
        check("rst_ready0", 64'(req0_ready),   64'd0);
        check("rst_ready1", 64'(req1_ready),   64'd0);

        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();

        // Lone req0: same-cycle ready, write one cycle later.
        req0_valid = 1'b1; req0_address = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        check("t1_ready0", 64'(req0_ready), 64'd1);
        check("t1_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0;
        check("t1_we",   64'(write_enable), 64'd1);
        check("t1_addr", 64'(address_d),    64'd5);
        check("t1_data", 64'(data_dval),    64'hDEADBEEF);
        tick();
        check("t1_we_off",   64'(write_enable), 64'd0);
        check("t1_addr_hold", 64'(address_d),   64'd5);

        // Lone req1 to register 0: handshake completes, no write strobe.
        req1_valid = 1'b1; req1_address = 5'd0; req1_data = 32'h1234;
        #1;
        check("t3_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        check("t3_we",        64'(write_enable), 64'd0);
        check("t3_addr_hold", 64'(address_d),    64'd5);
        check("t3_data_hold", 64'(data_dval),    64'hDEADBEEF);
        check("t3_stall",     64'(stall_count),  64'd0);

        // Both valid for 4 cycles: alternating grants starting at req0, no bubbles.
        req0_valid = 1'b1; req0_address = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_address = 5'd2; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t2_ready0_%0d", i), 64'(req0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("t2_ready1_%0d", i), 64'(req1_ready), (i % 2 == 1) ? 64'd1 : 64'd0);
            tick();
            check($sformatf("t2_we_%0d", i),   64'(write_enable), 64'd1);
            check($sformatf("t2_addr_%0d", i), 64'(address_d),    (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t2_stall", 64'(stall_count), 64'd4);

        // Same address from both: two ordered writes, later grant wins.
        req0_valid = 1'b1; req0_address = 5'd7; req0_data = 32'hA;
        req1_valid = 1'b1; req1_address = 5'd7; req1_data = 32'hB;
        #1;
        check("t5_ready0", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        check("t5_we_a",   64'(write_enable), 64'd1);
        check("t5_addr_a", 64'(address_d),    64'd7);
        check("t5_data_a", 64'(data_dval),    64'hA);
        #1;
        check("t5_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        check("t5_we_b",   64'(write_enable), 64'd1);
        check("t5_data_b", 64'(data_dval),    64'hB);
        tick();
        check("t5_we_off",  64'(write_enable), 64'd0);
        check("t5_final",   64'(data_dval),    64'hB);
        check("t5_stall",   64'(stall_count),  64'd5);

        // Stall counter saturation and clear precedence.
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        check("t4_clear0", 64'(stall_count), 64'd0);
        req0_valid = 1'b1; req0_address = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_address = 5'd4; req1_data = 32'h44;
        repeat (70000) tick();
        check("t4_sat", 64'(stall_count), 64'hFFFF);
        repeat (3) tick();
        check("t4_sat_hold", 64'(stall_count), 64'hFFFF);
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        check("t4_clear_prec", 64'(stall_count), 64'd0);
        tick();
        check("t4_resume", 64'(stall_count), 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Async reset mid-stream with pointer favouring req1.
        req0_valid = 1'b1; req0_address = 5'd12; req0_data = 32'hC;
        #1;
        check("t6_ready0", 64'(req0_ready), 64'd1);
        tick();
        req0_address = 5'd13; req0_data = 32'hD;
        req1_valid = 1'b1; req1_address = 5'd14; req1_data = 32'hE;
        #1;
        check("t6_ptr_ready1", 64'(req1_ready), 64'd1);
        check("t6_ptr_ready0", 64'(req0_ready), 64'd0);
        tick();
        check("t6_we_pre", 64'(write_enable), 64'd1);
        check("t6_addr_pre", 64'(address_d), 64'd14);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_we",     64'(write_enable), 64'd0);
        check("t6_rst_addr",   64'(address_d),    64'd0);
        check("t6_rst_data",   64'(data_dval),    64'd0);
        check("t6_rst_stall",  64'(stall_count),  64'd0);
        check("t6_rst_ready0", 64'(req0_ready),   64'd0);
        check("t6_rst_ready1", 64'(req1_ready),   64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("t6_no_pulse", 64'(write_enable), 64'd0);
        reset_n = 1'b1;
        tick(); tick();
        check("t6_post_we", 64'(write_enable), 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t6_post_ready0", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t6_post_wr_we",   64'(write_enable), 64'd1);
        check("t6_post_wr_addr", 64'(address_d),    64'd13);
        check("t6_post_wr_data", 64'(data_dval),    64'hD);
        check("t6_post_stall",   64'(stall_count),  64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
